// File: rtl/accelerator_scalar_integer_divider_pkg.sv
// Shared definitions for the scalar integer arithmetic family: the FSM
// state encoding (same numbering as the multiplier) and common constants.
package accelerator_integer_pkg;

   typedef enum logic [2:0] {
      STARTER_STATE = 3'd0,
      DIVIDE_STATE  = 3'd1,
      ENDER_STATE   = 3'd2
   } state_t;

   localparam int unsigned CONTROL_SIZE_DEFAULT = 4;

   localparam logic [63:0] ZERO_DATA = 64'd0;
   localparam logic [63:0] ONE_DATA  = 64'd1;

   localparam logic [CONTROL_SIZE_DEFAULT-1:0] ZERO_CONTROL = 4'd0;
   localparam logic [CONTROL_SIZE_DEFAULT-1:0] ONE_CONTROL  = 4'd1;

endpackage

// File: rtl/accelerator_scalar_integer_divider_if.sv
// START/READY handshake and operand/result bus of the scalar divider.
interface accelerator_scalar_integer_divider_if #(
   parameter int DATA_SIZE = 64
);
   logic                 START;
   logic                 READY;
   logic [DATA_SIZE-1:0] DATA_A_IN;
   logic [DATA_SIZE-1:0] DATA_B_IN;
   logic [DATA_SIZE-1:0] DATA_OUT;
   logic [DATA_SIZE-1:0] REMAINDER_OUT;
   logic                 DIVIDE_BY_ZERO;

   // Requester side.
   modport master (
      output START, DATA_A_IN, DATA_B_IN,
      input  READY, DATA_OUT, REMAINDER_OUT, DIVIDE_BY_ZERO
   );

   // Divider side.
   modport slave (
      input  START, DATA_A_IN, DATA_B_IN,
      output READY, DATA_OUT, REMAINDER_OUT, DIVIDE_BY_ZERO
   );
endinterface

// File: rtl/accelerator_scalar_integer_divider_step.sv
// One restoring shift-compare-subtract step: shift the next dividend bit
// into the partial remainder and subtract the divisor when it fits.
module accelerator_scalar_integer_divider_step #(
   parameter int DATA_SIZE = 64
) (
   input  logic [DATA_SIZE:0]   r,
   input  logic                 q_msb,
   input  logic [DATA_SIZE-1:0] d,
   output logic [DATA_SIZE:0]   r_next,
   output logic                 q_bit
);
   logic [DATA_SIZE:0] t;
   logic [DATA_SIZE:0] d_ext;
   logic               unused_guard;

   // The partial remainder is always below the divisor between steps, so
   // its guard bit is zero here; the shifted-out MSB lands in t's top bit.
   assign unused_guard = r[DATA_SIZE];
   assign t            = {r[DATA_SIZE-1:0], q_msb};
   assign d_ext        = {1'b0, d};

   // Restore (keep t) when the divisor does not fit, otherwise subtract it.
   always_comb begin
      r_next = t;
      q_bit  = 1'b0;
      if (t >= d_ext) begin
         r_next = t - d_ext;
         q_bit  = 1'b1;
      end else begin
         r_next = t;
         q_bit  = 1'b0;
      end
   end
endmodule

// File: rtl/accelerator_scalar_integer_divider.sv
// Multi-cycle unsigned divider: one quotient bit per clock by restoring
// shift-subtract, results presented with a one-cycle READY pulse.
module accelerator_scalar_integer_divider
   import accelerator_integer_pkg::*;
#(
   parameter int DATA_SIZE    = 64,
   parameter int CONTROL_SIZE = 4
) (
   input logic CLK,
   input logic RST,
   accelerator_scalar_integer_divider_if.slave bus
);
   localparam int INDEX_W = $clog2(DATA_SIZE) + 1;
   localparam logic [INDEX_W-1:0]   LAST_INDEX = INDEX_W'(DATA_SIZE - 1);
   localparam logic [INDEX_W-1:0]   INDEX_ONE  = INDEX_W'(ONE_DATA);
   localparam logic [DATA_SIZE-1:0] DATA_ZERO  = DATA_SIZE'(ZERO_DATA);
   localparam logic [DATA_SIZE-1:0] DATA_ONES  = ~DATA_ZERO;

   if (DATA_SIZE < 2 || CONTROL_SIZE < 1) begin : g_param_check
      $error("accelerator_scalar_integer_divider: DATA_SIZE must be >= 2");
   end

   state_t               state;
   logic [DATA_SIZE-1:0] q_int;
   logic [DATA_SIZE-1:0] d_int;
   logic [DATA_SIZE:0]   r_int;
   logic [INDEX_W-1:0]   index_int;

   logic                 ready;
   logic [DATA_SIZE-1:0] data_out;
   logic [DATA_SIZE-1:0] remainder_out;
   logic                 divide_by_zero;

   logic [DATA_SIZE:0]   r_next;
   logic                 q_bit;

   accelerator_scalar_integer_divider_step #(
      .DATA_SIZE (DATA_SIZE)
   ) u_step (
      .r      (r_int),
      .q_msb  (q_int[DATA_SIZE-1]),
      .d      (d_int),
      .r_next (r_next),
      .q_bit  (q_bit)
   );

   // Control FSM and datapath: capture operands, iterate, publish results.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state          <= STARTER_STATE;
         q_int          <= DATA_ZERO;
         d_int          <= DATA_ZERO;
         r_int          <= {1'b0, DATA_ZERO};
         index_int      <= '0;
         ready          <= 1'b0;
         data_out       <= DATA_ZERO;
         remainder_out  <= DATA_ZERO;
         divide_by_zero <= 1'b0;
      end else begin
         case (state)
            STARTER_STATE: begin
               ready <= 1'b0;
               if (bus.START) begin
                  q_int     <= bus.DATA_A_IN;
                  d_int     <= bus.DATA_B_IN;
                  r_int     <= {1'b0, DATA_ZERO};
                  index_int <= '0;
                  state     <= (bus.DATA_B_IN == DATA_ZERO) ? ENDER_STATE : DIVIDE_STATE;
               end
            end
            DIVIDE_STATE: begin
               r_int     <= r_next;
               q_int     <= {q_int[DATA_SIZE-2:0], q_bit};
               index_int <= index_int + INDEX_ONE;
               if (index_int == LAST_INDEX) begin
                  state <= ENDER_STATE;
               end
            end
            ENDER_STATE: begin
               // A zero divisor skipped iteration, so q_int still holds the dividend.
               if (d_int == DATA_ZERO) begin
                  data_out       <= DATA_ONES;
                  remainder_out  <= q_int;
                  divide_by_zero <= 1'b1;
               end else begin
                  data_out       <= q_int;
                  remainder_out  <= r_int[DATA_SIZE-1:0];
                  divide_by_zero <= 1'b0;
               end
               ready <= 1'b1;
               state <= STARTER_STATE;
            end
            default: begin
               state <= STARTER_STATE;
            end
         endcase
      end
   end

   assign bus.READY          = ready;
   assign bus.DATA_OUT       = data_out;
   assign bus.REMAINDER_OUT  = remainder_out;
   assign bus.DIVIDE_BY_ZERO = divide_by_zero;
endmodule

// File: tb/tb_accelerator_scalar_integer_divider.sv
// Self-checking bench for the scalar divider against plain / and % arithmetic.
module tb_accelerator_scalar_integer_divider;
   localparam int DS = 64;
   localparam logic [DS-1:0] ALL_ONES = {DS{1'b1}};

   logic CLK = 1'b0;
   logic RST = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   accelerator_scalar_integer_divider_if #(.DATA_SIZE(DS)) bus();

   accelerator_scalar_integer_divider #(
      .DATA_SIZE    (DS),
      .CONTROL_SIZE (4)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   // Issue one request, return the result and the START-edge-to-READY latency
   // (0 when READY never arrives). Returns at the negedge of the READY cycle.
   task automatic run_op(input logic [DS-1:0] a, input logic [DS-1:0] b,
                         output logic [DS-1:0] q, output logic [DS-1:0] r,
                         output logic dbz, output int lat);
      lat = 0;
      q   = '0;
      r   = '0;
      dbz = 1'b0;
      @(negedge CLK);
      bus.START     = 1'b1;
      bus.DATA_A_IN = a;
      bus.DATA_B_IN = b;
      @(posedge CLK);
      @(negedge CLK);
      bus.START     = 1'b0;
      bus.DATA_A_IN = {$urandom(), $urandom()};
      bus.DATA_B_IN = {$urandom(), $urandom()};
      for (int n = 1; n <= 200; n++) begin
         @(posedge CLK);
         @(negedge CLK);
         if (bus.READY === 1'b1) begin
            lat = n;
            q   = bus.DATA_OUT;
            r   = bus.REMAINDER_OUT;
            dbz = bus.DIVIDE_BY_ZERO;
            break;
         end
      end
   endtask

   task automatic test_reset();
      RST = 1'b0;
      bus.START = 1'b0;
      bus.DATA_A_IN = '0;
      bus.DATA_B_IN = '0;
      repeat (2) @(negedge CLK);
      checks++;
      if (bus.READY !== 1'b0 || bus.DATA_OUT !== '0 || bus.REMAINDER_OUT !== '0 || bus.DIVIDE_BY_ZERO !== 1'b0) begin
         failures++;
         $display("FAIL reset_state got rdy=%b q=%h r=%h dbz=%b exp all zero",
                  bus.READY, bus.DATA_OUT, bus.REMAINDER_OUT, bus.DIVIDE_BY_ZERO);
      end
      RST = 1'b1;
      repeat (2) @(negedge CLK);
   endtask

   task automatic test_basic();
      logic [DS-1:0] q, r;
      logic dbz;
      int lat;
      run_op(64'd100, 64'd7, q, r, dbz, lat);
      checks++;
      if (lat !== 65 || q !== 64'd14 || r !== 64'd2 || dbz !== 1'b0) begin
         failures++;
         $display("FAIL basic_100_7 got lat=%0d q=%0d r=%0d dbz=%b exp lat=65 q=14 r=2 dbz=0", lat, q, r, dbz);
      end
      @(negedge CLK);
      checks++;
      if (bus.READY !== 1'b0) begin
         failures++;
         $display("FAIL ready_one_cycle got ready=%b exp 0", bus.READY);
      end
      repeat (3) @(negedge CLK);
      checks++;
      if (bus.DATA_OUT !== 64'd14 || bus.REMAINDER_OUT !== 64'd2 || bus.READY !== 1'b0) begin
         failures++;
         $display("FAIL result_hold got q=%0d r=%0d rdy=%b exp q=14 r=2 rdy=0", bus.DATA_OUT, bus.REMAINDER_OUT, bus.READY);
      end
   endtask

   task automatic test_div_zero();
      logic [DS-1:0] q, r;
      logic dbz;
      int lat;
      run_op(64'd5, 64'd0, q, r, dbz, lat);
      checks++;
      if (lat !== 1 || q !== ALL_ONES || r !== 64'd5 || dbz !== 1'b1) begin
         failures++;
         $display("FAIL div_zero got lat=%0d q=%h r=%0d dbz=%b exp lat=1 q=%h r=5 dbz=1", lat, q, r, dbz, ALL_ONES);
      end
   endtask

   task automatic test_boundaries();
      logic [DS-1:0] a_tab [5];
      logic [DS-1:0] b_tab [5];
      logic [DS-1:0] q_tab [5];
      logic [DS-1:0] r_tab [5];
      logic [DS-1:0] q, r;
      logic dbz;
      int lat;
      a_tab[0] = ALL_ONES;              b_tab[0] = ALL_ONES; q_tab[0] = 64'd1;                  r_tab[0] = 64'd0;
      a_tab[1] = 64'h8000_0000_0000_0000; b_tab[1] = 64'd3;  q_tab[1] = 64'h2AAA_AAAA_AAAA_AAAA; r_tab[1] = 64'd2;
      a_tab[2] = 64'd12345;             b_tab[2] = 64'd99999; q_tab[2] = 64'd0;                 r_tab[2] = 64'd12345;
      a_tab[3] = 64'd0;                 b_tab[3] = 64'd17;   q_tab[3] = 64'd0;                  r_tab[3] = 64'd0;
      a_tab[4] = 64'hDEAD_BEEF_CAFE_F00D; b_tab[4] = 64'd1;  q_tab[4] = 64'hDEAD_BEEF_CAFE_F00D; r_tab[4] = 64'd0;
      for (int i = 0; i < 5; i++) begin
         run_op(a_tab[i], b_tab[i], q, r, dbz, lat);
         checks++;
         if (lat !== 65 || q !== q_tab[i] || r !== r_tab[i] || dbz !== 1'b0) begin
            failures++;
            $display("FAIL boundary_%0d got lat=%0d q=%h r=%h dbz=%b exp lat=65 q=%h r=%h dbz=0",
                     i, lat, q, r, dbz, q_tab[i], r_tab[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [DS-1:0] q, r;
      logic dbz;
      int lat;
      int n;
      run_op(64'd1000, 64'd10, q, r, dbz, lat);
      checks++;
      if (lat !== 65 || q !== 64'd100 || r !== 64'd0) begin
         failures++;
         $display("FAIL b2b_first got lat=%0d q=%0d r=%0d exp lat=65 q=100 r=0", lat, q, r);
      end
      // Still inside the READY cycle: request again.
      bus.START     = 1'b1;
      bus.DATA_A_IN = 64'd9;
      bus.DATA_B_IN = 64'd4;
      @(posedge CLK);
      n = 1;
      @(negedge CLK);
      bus.START = 1'b0;
      checks++;
      if (bus.DATA_OUT !== 64'd100 || bus.READY !== 1'b0) begin
         failures++;
         $display("FAIL b2b_hold_on_start got q=%0d rdy=%b exp q=100 rdy=0", bus.DATA_OUT, bus.READY);
      end
      for (int k = 0; k < 200; k++) begin
         @(posedge CLK);
         n++;
         @(negedge CLK);
         if (bus.READY === 1'b1) break;
         bus.START     = (n == 10) ? 1'b1 : 1'b0;
         bus.DATA_A_IN = (n == 10) ? 64'd77 : {$urandom(), $urandom()};
         bus.DATA_B_IN = (n == 10) ? 64'd3  : {$urandom(), $urandom()};
      end
      bus.START = 1'b0;
      checks++;
      if (bus.READY !== 1'b1 || n !== 66 || bus.DATA_OUT !== 64'd2 || bus.REMAINDER_OUT !== 64'd1 || bus.DIVIDE_BY_ZERO !== 1'b0) begin
         failures++;
         $display("FAIL b2b_second got rdy=%b gap=%0d q=%0d r=%0d dbz=%b exp rdy=1 gap=66 q=2 r=1 dbz=0",
                  bus.READY, n, bus.DATA_OUT, bus.REMAINDER_OUT, bus.DIVIDE_BY_ZERO);
      end
   endtask

   task automatic test_reset_mid_op();
      logic [DS-1:0] q, r;
      logic dbz;
      int lat;
      int seen_ready;
      run_op(64'd100, 64'd7, q, r, dbz, lat);
      @(negedge CLK);
      bus.START     = 1'b1;
      bus.DATA_A_IN = 64'd1234;
      bus.DATA_B_IN = 64'd5;
      @(posedge CLK);
      @(negedge CLK);
      bus.START = 1'b0;
      repeat (29) @(posedge CLK);
      #1 RST = 1'b0;
      #1;
      checks++;
      if (bus.READY !== 1'b0 || bus.DATA_OUT !== '0 || bus.REMAINDER_OUT !== '0 || bus.DIVIDE_BY_ZERO !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_op got rdy=%b q=%h r=%h dbz=%b exp all zero",
                  bus.READY, bus.DATA_OUT, bus.REMAINDER_OUT, bus.DIVIDE_BY_ZERO);
      end
      seen_ready = 0;
      for (int k = 0; k < 80; k++) begin
         @(negedge CLK);
         if (k == 3) RST = 1'b1;
         if (bus.READY === 1'b1) seen_ready++;
      end
      checks++;
      if (seen_ready !== 0) begin
         failures++;
         $display("FAIL reset_no_ready got ready_pulses=%0d exp 0", seen_ready);
      end
      run_op(64'd1234, 64'd5, q, r, dbz, lat);
      checks++;
      if (lat !== 65 || q !== 64'd246 || r !== 64'd4 || dbz !== 1'b0) begin
         failures++;
         $display("FAIL after_reset got lat=%0d q=%0d r=%0d dbz=%b exp lat=65 q=246 r=4 dbz=0", lat, q, r, dbz);
      end
   endtask

   task automatic test_random();
      logic [DS-1:0] a, b, q, r, exp_q, exp_r;
      logic dbz, exp_dbz;
      int lat, exp_lat;
      for (int i = 0; i < 600; i++) begin
         a = {$urandom(), $urandom()};
         case ($urandom_range(0, 5))
            0: b = 64'd1;
            1: b = 64'd0;
            2: begin b = {$urandom(), $urandom()} | 64'd1; a = a % b; end
            3: begin a = 64'($urandom_range(0, 255)); b = 64'($urandom_range(1, 255)); end
            default: b = {$urandom(), $urandom()} >> $urandom_range(0, 63);
         endcase
         if (b == 64'd0) begin
            exp_q = ALL_ONES; exp_r = a; exp_dbz = 1'b1; exp_lat = 1;
         end else begin
            exp_q = a / b; exp_r = a % b; exp_dbz = 1'b0; exp_lat = DS + 1;
         end
         run_op(a, b, q, r, dbz, lat);
         checks++;
         if (lat !== exp_lat || q !== exp_q || r !== exp_r || dbz !== exp_dbz) begin
            failures++;
            $display("FAIL random_%0d a=%h b=%h got lat=%0d q=%h r=%h dbz=%b exp lat=%0d q=%h r=%h dbz=%b",
                     i, a, b, lat, q, r, dbz, exp_lat, exp_q, exp_r, exp_dbz);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_div_zero();
      test_boundaries();
      test_back_to_back();
      test_reset_mid_op();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
